instr_fetch_unit: RTL and testbench

Instruction fetch stage of the RV32I core: owns the program counter, fetches words from instruction memory over a req/ack handshake and buffers them in a small FIFO. It presents {instruction, PC} pairs to the decode/Control_Unit stage. On a taken branch (PCSrc), it redirects to PC+ImmExt and flushes fall-through work. This block replaces the ideal combinational instruction ROM with a memory that may insert wait states.

---
 rtl/instr_fetch_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage of the RV32I core. Owns the program counter, issues
// one word fetch at a time to instruction memory over a req/ack handshake and
// buffers returned words, tagged with their PC, in a small shift FIFO whose
// head feeds the decode stage. A taken branch (PCSrc on the consumed head)
// flushes the FIFO and redirects fetch to instr_pc + ImmExt. A request still
// in flight at redirect time is drained with its address held and its data
// discarded. A misaligned redirect target latches misalign_err and parks the
// unit in HALT until reset.
//
// Parameters:
//   RESET_PC     first fetch address after reset
//   DEPTH        FIFO entries (power of two, >= 2)
//
// Ports:
//   clk          core clock, rising edge
//   rst_n        asynchronous active-low reset
//   imem_req     fetch request, held until imem_ack
//   imem_addr    word address of the request, stable while imem_req=1
//   imem_ack     request complete, imem_rdata valid this cycle
//   imem_rdata   fetched instruction word
//   instr        FIFO head instruction
//   instr_pc     PC of FIFO head
//   instr_valid  FIFO non-empty and not halted
//   instr_ready  consumer takes the head this cycle when instr_valid=1
//   PCSrc        branch taken for the head being consumed
//   ImmExt       sign-extended branch offset for the head
//   misalign_err sticky flag: a redirect target was not word-aligned
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 32'sd2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        PCSrc,
  input  logic [31:0] ImmExt,
  output logic        misalign_err
);

  localparam int CW = $clog2(DEPTH + 32'sd1);
  typedef logic [CW-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  // Registered state
  state_t      state_r;
  logic [31:0] fetch_pc_r;
  logic [31:0] addr_r;
  logic        req_r;
  logic        valid_r;
  logic        misalign_r;
  logic        halt_pend_r;
  cnt_t        count_r;
  logic [31:0] pc_q_r  [DEPTH];
  logic [31:0] ins_q_r [DEPTH];

  // Next-state values
  state_t      state_n_s;
  logic [31:0] fetch_pc_n_s;
  logic [31:0] addr_n_s;
  logic        req_n_s;
  logic        valid_n_s;
  logic        misalign_n_s;
  logic        halt_pend_n_s;
  cnt_t        count_n_s;
  logic [31:0] pc_q_n_s  [DEPTH];
  logic [31:0] ins_q_n_s [DEPTH];

  // Handshake decode
  logic        consume_s;
  logic        redirect_s;
  logic [31:0] target_s;
  logic        bad_tgt_s;
  logic        push_s;
  logic        pop_s;
  logic        space_s;
  cnt_t        wr_idx_s;

  assign consume_s  = valid_r & instr_ready;
  assign redirect_s = consume_s & PCSrc;
  assign target_s   = pc_q_r[0] + ImmExt;
  assign bad_tgt_s  = redirect_s & (target_s[1:0] != 2'b00);
  // Only an ack to a live (non-stale) request delivers data; a redirect in
  // the same cycle makes that word fall-through work, so it is dropped.
  assign push_s     = (state_r == ST_REQ) & imem_ack & ~redirect_s;
  assign pop_s      = consume_s & ~redirect_s;
  // After a pop the entries shift down one slot, so the free slot moves too.
  assign wr_idx_s   = count_r - (pop_s ? cnt_t'(1'b1) : cnt_t'(1'b0));
  assign space_s    = (count_n_s < cnt_t'(DEPTH));

  // FIFO occupancy and fetch PC update
  always_comb begin
    count_n_s     = count_r;
    fetch_pc_n_s  = fetch_pc_r;
    halt_pend_n_s = halt_pend_r | bad_tgt_s;
    misalign_n_s  = misalign_r | bad_tgt_s;
    if (redirect_s) begin
      count_n_s    = cnt_t'(1'b0);
      fetch_pc_n_s = target_s;
    end else begin
      count_n_s = count_r + (push_s ? cnt_t'(1'b1) : cnt_t'(1'b0))
                          - (pop_s  ? cnt_t'(1'b1) : cnt_t'(1'b0));
      fetch_pc_n_s = push_s ? (fetch_pc_r + 32'd4) : fetch_pc_r;
    end
  end

  // FIFO storage: shift on pop, write returned word into the first free slot
  always_comb begin
    pc_q_n_s  = pc_q_r;
    ins_q_n_s = ins_q_r;
    for (int i = 32'sd0; i < DEPTH - 32'sd1; i++) begin
      pc_q_n_s[i]  = pop_s ? pc_q_r[i + 32'sd1]  : pc_q_r[i];
      ins_q_n_s[i] = pop_s ? ins_q_r[i + 32'sd1] : ins_q_r[i];
    end
    for (int i = 32'sd0; i < DEPTH; i++) begin
      pc_q_n_s[i]  = (push_s && (cnt_t'(i) == wr_idx_s)) ? addr_r     : pc_q_n_s[i];
      ins_q_n_s[i] = (push_s && (cnt_t'(i) == wr_idx_s)) ? imem_rdata : ins_q_n_s[i];
    end
  end

  // Fetch FSM next state and next registered outputs
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bad_tgt_s) begin
          state_n_s = ST_HALT;
        end else if (space_s) begin
          state_n_s = ST_REQ;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bad_tgt_s) begin
          // Outstanding request must still complete before parking.
          state_n_s = imem_ack ? ST_HALT : ST_DROP;
        end else if (redirect_s) begin
          // FIFO was just flushed, so space always exists for the target.
          state_n_s = imem_ack ? ST_REQ : ST_DROP;
        end else if (imem_ack) begin
          state_n_s = space_s ? ST_REQ : ST_IDLE;
        end else begin
          state_n_s = ST_REQ;
        end
      end
      ST_DROP: begin
        if (imem_ack) begin
          if (halt_pend_n_s) begin
            state_n_s = ST_HALT;
          end else if (space_s) begin
            state_n_s = ST_REQ;
          end else begin
            state_n_s = ST_IDLE;
          end
        end else begin
          state_n_s = ST_DROP;
        end
      end
      ST_HALT: begin
        state_n_s = ST_HALT;
      end
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase

    req_n_s   = (state_n_s == ST_REQ) || (state_n_s == ST_DROP);
    // A live request always targets fetch_pc; in DROP the stale address is
    // held so the memory sees a stable request until it acks.
    addr_n_s  = (state_n_s == ST_REQ) ? fetch_pc_n_s : addr_r;
    valid_n_s = (count_n_s != cnt_t'(1'b0)) && (state_n_s != ST_HALT);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      fetch_pc_r  <= RESET_PC;
      addr_r      <= RESET_PC;
      req_r       <= 1'b0;
      valid_r     <= 1'b0;
      misalign_r  <= 1'b0;
      halt_pend_r <= 1'b0;
      count_r     <= cnt_t'(1'b0);
      for (int i = 32'sd0; i < DEPTH; i++) begin
        pc_q_r[i]  <= 32'h0000_0000;
        ins_q_r[i] <= 32'h0000_0000;
      end
    end else begin
      state_r     <= state_n_s;
      fetch_pc_r  <= fetch_pc_n_s;
      addr_r      <= addr_n_s;
      req_r       <= req_n_s;
      valid_r     <= valid_n_s;
      misalign_r  <= misalign_n_s;
      halt_pend_r <= halt_pend_n_s;
      count_r     <= count_n_s;
      for (int i = 32'sd0; i < DEPTH; i++) begin
        pc_q_r[i]  <= pc_q_n_s[i];
        ins_q_r[i] <= ins_q_n_s[i];
      end
    end
  end

  assign imem_req     = req_r;
  assign imem_addr    = addr_r;
  assign instr        = ins_q_r[0];
  assign instr_pc     = pc_q_r[0];
  assign instr_valid  = valid_r;
  assign misalign_err = misalign_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Randomised bench for instr_fetch_unit. A memory model answers requests with
// a configurable number of wait states. A driver issues consumer handshakes
// and branch decisions; each accepted head makes an architectural PC model
// (next = PCSrc ? pc+imm : pc+4) push the next expected PC onto a queue. A
// monitor compares every presented head with the queue front and pops on
// consume. Directed phases cover reset, throughput, back-pressure, stale
// request drop, misaligned redirect and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        PCSrc;
  logic [31:0] ImmExt;
  logic        misalign_err;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .PCSrc       (PCSrc),
    .ImmExt      (ImmExt),
    .misalign_err(misalign_err)
  );

  int tests = 0;
  int fails = 0;
  int sb_pops = 0;

  // stimulus configuration
  int          wait_max   = 0;
  bit          rand_wait  = 1'b0;
  int          ready_mode = 1;     // 0 never, 1 always, 2 random
  bit          branch_en  = 1'b0;
  bit          redir_armed = 1'b0;
  logic [31:0] redir_pc    = 32'h0;
  logic [31:0] redir_imm   = 32'h0;
  bit          redir_fired = 1'b0;
  bit          mis_armed   = 1'b0;
  bit          mis_fired   = 1'b0;
  bit          late_ack    = 1'b0;

  // reference model
  logic [31:0] model_pc;
  bit          halted_m;
  logic [31:0] exp_q [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    model_pc    = RESET_PC;
    halted_m    = 1'b0;
    redir_armed = 1'b0;
    redir_fired = 1'b0;
    mis_armed   = 1'b0;
    mis_fired   = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memory: ack after wait states, response settles 2 time units after posedge
  int wcnt = 0;
  int cur_wait = 0;
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (late_ack) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        wcnt       = 0;
      end else if (!rst_n || !imem_req) begin
        imem_ack = 1'b0;
        wcnt     = 0;
      end else begin
        if (wcnt == 0) cur_wait = rand_wait ? int'($urandom_range(0, wait_max)) : wait_max;
        if (wcnt >= cur_wait) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          wcnt       = 0;
        end else begin
          imem_ack = 1'b0;
          wcnt++;
        end
      end
    end
  end

  // driver: consumer handshake and branch decisions, 1 time unit after posedge
  logic        d_rdy, d_pcs;
  logic [31:0] d_imm, d_nxt;
  int          d_off;
  initial begin
    instr_ready = 1'b0;
    PCSrc       = 1'b0;
    ImmExt      = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
      end else begin
        d_rdy = (ready_mode == 1) || (ready_mode == 2 && $urandom_range(0, 3) != 0);
        d_pcs = 1'($urandom_range(0, 1));   // noise, ignored unless consumed
        d_imm = $urandom;
        if (instr_valid && d_rdy && !halted_m) begin
          d_pcs = 1'b0;
          if (mis_armed) begin
            d_pcs = 1'b1; d_imm = 32'h0000_0006; mis_armed = 1'b0; mis_fired = 1'b1;
          end else if (redir_armed && model_pc == redir_pc) begin
            d_pcs = 1'b1; d_imm = redir_imm; redir_armed = 1'b0; redir_fired = 1'b1;
          end else if (branch_en && $urandom_range(0, 7) == 0) begin
            d_off = int'($urandom_range(0, 63)) - 32;
            d_pcs = 1'b1; d_imm = 32'(d_off * 4);
          end
          d_nxt = d_pcs ? (model_pc + d_imm) : (model_pc + 32'd4);
          if (d_pcs && d_nxt[1:0] != 2'b00) halted_m = 1'b1;
          else exp_q.push_back(d_nxt);
          model_pc = d_nxt;
        end
        instr_ready = d_rdy;
        PCSrc       = d_pcs;
        ImmExt      = d_imm;
      end
    end
  end

  // monitor: head scoreboard and request-stability check at negedge
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 1'b0;
      end else begin
        if (instr_valid) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL sb_unexpected_head: actual pc=%h expected no head at %0t", instr_pc, $time);
          end else begin
            chk("sb_pc", instr_pc, exp_q[0]);
            chk("sb_instr", instr, mem_word(exp_q[0]));
            if (instr_ready) begin
              void'(exp_q.pop_front());
              sb_pops++;
            end
          end
        end
        if (prev_req && !prev_ack) begin
          chk("req_held", {31'd0, imem_req}, 32'd1);
          chk("addr_stable", imem_addr, prev_addr);
        end
        prev_req  = imem_req;
        prev_ack  = imem_ack;
        prev_addr = imem_addr;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int n;
  int v;
  logic [31:0] pa;

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    chk("rst_mis", {31'd0, misalign_err}, 32'd0);
    model_reset();
    wait_max = 0; rand_wait = 1'b0; ready_mode = 1; branch_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // zero-wait streaming
    @(negedge clk);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RESET_PC);
    chk("first_valid", {31'd0, instr_valid}, 32'd0);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk("zw_req", {31'd0, imem_req}, 32'd1);
      chk("zw_addr", imem_addr, 32'(i * 4));
      chk("zw_valid", {31'd0, instr_valid}, 32'd1);
    end

    // three wait states
    wait_max = 3;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      pa = imem_addr; n = 0;
      while (imem_addr == pa && n < 20) begin @(negedge clk); n++; end
    end
    chk("wait3_hold", 32'(n), 32'd4);
    v = 0;
    repeat (12) begin @(negedge clk); if (instr_valid) v++; end
    chk("wait3_valid_rate", 32'(v), 32'd3);

    // asynchronous reset with a request pending, late ack ignored
    n = 0;
    while (!(imem_req && !imem_ack) && n < 20) begin @(negedge clk); n++; end
    chk("pending_found", {31'd0, imem_req & ~imem_ack}, 32'd1);
    #1 rst_n = 1'b0;
    late_ack = 1'b1; wait_max = 0; ready_mode = 0;
    model_reset();
    #1;
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_addr", imem_addr, RESET_PC);
    chk("arst_valid", {31'd0, instr_valid}, 32'd0);
    chk("arst_instr", instr, 32'd0);
    chk("arst_pc", instr_pc, 32'd0);
    chk("arst_mis", {31'd0, misalign_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 late_ack = 1'b0;
    @(negedge clk);
    chk("rerst_req", {31'd0, imem_req}, 32'd1);
    chk("rerst_addr", imem_addr, RESET_PC);

    // back-pressure: FIFO fills, requests stop, drain resumes at 0x8
    repeat (10) @(negedge clk);
    chk("bp_valid", {31'd0, instr_valid}, 32'd1);
    chk("bp_req", {31'd0, imem_req}, 32'd0);
    chk("bp_head", instr_pc, 32'h0);
    ready_mode = 1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_resume_req", {31'd0, imem_req}, 32'd1);
    chk("bp_resume_addr", imem_addr, 32'h8);

    // redirect at 0x10 back to 0x0 with a stale request outstanding
    wait_max = 2; ready_mode = 1;
    reset_dut();
    redir_pc = 32'h10; redir_imm = 32'hFFFF_FFF0; redir_armed = 1'b1;
    n = 0;
    while (!redir_fired && n < 100) begin @(negedge clk); n++; end
    chk("redir_fired", {31'd0, redir_fired}, 32'd1);
    @(negedge clk);
    chk("redir_valid", {31'd0, instr_valid}, 32'd0);
    chk("drop_req", {31'd0, imem_req}, 32'd1);
    chk("drop_addr", imem_addr, 32'h14);
    n = 0;
    while (!imem_ack && n < 10) begin
      @(negedge clk); n++;
      chk("drop_req", {31'd0, imem_req}, 32'd1);
      chk("drop_addr", imem_addr, 32'h14);
    end
    chk("drop_wait", 32'(n), 32'd1);
    @(negedge clk);
    chk("redir_req", {31'd0, imem_req}, 32'd1);
    chk("redir_addr", imem_addr, 32'h0);

    // random traffic: wait states, back-pressure and branches
    wait_max = 3; rand_wait = 1'b1; ready_mode = 2; branch_en = 1'b1;
    repeat (400) @(negedge clk);
    branch_en = 1'b0; ready_mode = 1; rand_wait = 1'b0; wait_max = 0;
    repeat (12) @(negedge clk);
    chk("sb_activity", {31'd0, sb_pops > 60}, 32'd1);

    // misaligned redirect parks the unit
    mis_armed = 1'b1;
    n = 0;
    while (!mis_fired && n < 50) begin @(negedge clk); n++; end
    chk("mis_fired", {31'd0, mis_fired}, 32'd1);
    @(negedge clk);
    chk("mis_err", {31'd0, misalign_err}, 32'd1);
    chk("mis_valid", {31'd0, instr_valid}, 32'd0);
    chk("mis_req", {31'd0, imem_req}, 32'd0);
    repeat (10) begin
      @(negedge clk);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_err", {31'd0, misalign_err}, 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
